// File: rtl/triangle_cmd_sequencer_pkg.sv
// Shared types for the triangle command sequencer: FSM state encoding,
// the queued command record and the vertex packing offsets.
package triangle_cmd_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_ARM   = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    localparam int COORD_W = 8;
    localparam int VERT_W  = 6 * COORD_W;
    localparam int COLOR_W = 24;
    localparam int CMD_W   = VERT_W + 1 + COLOR_W;

    // Vertex word is {x0,y0,x1,y1,x2,y2}, x0 in the top byte.
    localparam int X0_LSB = 40;
    localparam int Y0_LSB = 32;
    localparam int X1_LSB = 24;
    localparam int Y1_LSB = 16;
    localparam int X2_LSB = 8;
    localparam int Y2_LSB = 0;

    typedef struct packed {
        logic [VERT_W-1:0]  vert;
        logic               fill;
        logic [COLOR_W-1:0] color;
    } tri_cmd_t;

    function automatic logic [VERT_W-1:0] pack_vert(
        input logic [COORD_W-1:0] x0, input logic [COORD_W-1:0] y0,
        input logic [COORD_W-1:0] x1, input logic [COORD_W-1:0] y1,
        input logic [COORD_W-1:0] x2, input logic [COORD_W-1:0] y2
    );
        logic [VERT_W-1:0] v;
        v = '0;
        v[X0_LSB +: COORD_W] = x0;
        v[Y0_LSB +: COORD_W] = y0;
        v[X1_LSB +: COORD_W] = x1;
        v[Y1_LSB +: COORD_W] = y1;
        v[X2_LSB +: COORD_W] = x2;
        v[Y2_LSB +: COORD_W] = y2;
        return v;
    endfunction

endpackage

// File: rtl/triangle_cmd_sequencer_fifo.sv
// Command FIFO: registered storage, no push-to-pop bypass. Full is taken
// from the occupancy register only, so a pop in a full cycle does not
// reopen the input until the following cycle.
module tri_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 73
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage write; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/triangle_cmd_sequencer.sv
// Triangle command sequencer: queues draw commands and hands them one at a
// time to the rasterizer, counting pixels and completed triangles, with a
// watchdog on the rasterizer completion.
module triangle_cmd_sequencer
    import triangle_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [47:0] cmd_vert,
    input  logic        cmd_fill,
    input  logic [23:0] cmd_color,
    output logic        tri_start,
    output logic [47:0] tri_vert,
    output logic        tri_fill,
    output logic [23:0] tri_color,
    input  logic        tri_valid,
    input  logic        tri_done,
    output logic        busy,
    output logic [15:0] pix_count,
    output logic [15:0] tri_count,
    output logic        timeout_err
);
    localparam int             WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    // Handshake: a command transfers on every rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready depends only on registered FIFO
    // occupancy, and the producer must hold data stable while valid is high.
    tri_cmd_t         cmd_in;
    tri_cmd_t         head;
    logic [CMD_W-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    state_e           state_q, state_d;
    logic [47:0]      vert_q, vert_d;
    logic             fill_q, fill_d;
    logic [23:0]      color_q, color_d;
    logic [15:0]      pix_q, pix_d;
    logic [15:0]      tcnt_q, tcnt_d;
    logic             terr_q, terr_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             pix_inc;

    assign cmd_in = '{vert: cmd_vert, fill: cmd_fill, color: cmd_color};
    assign head   = tri_cmd_t'(fifo_rdata);
    assign pop    = (state_q == ST_IDLE) && !fifo_empty;

    tri_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid),
        .wdata_i (cmd_in),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Pixels only count while the rasterizer is armed or running; saturate.
    assign pix_inc = tri_valid && ((state_q == ST_ARM) || (state_q == ST_WAIT))
                     && (pix_q != 16'hFFFF);

    // Next-state logic. ARM exists so a done level left over from the
    // previous triangle is never mistaken for completion of the new one.
    always_comb begin
        state_d = state_q;
        vert_d  = vert_q;
        fill_d  = fill_q;
        color_d = color_q;
        pix_d   = pix_inc ? pix_q + 16'd1 : pix_q;
        tcnt_d  = tcnt_q;
        terr_d  = terr_q;
        wd_d    = wd_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    vert_d  = head.vert;
                    fill_d  = head.fill;
                    color_d = head.color;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                pix_d   = '0;
                wd_d    = '0;
                state_d = ST_ARM;
            end
            ST_ARM: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tri_done) begin
                    tcnt_d  = tcnt_q + 16'd1;
                    state_d = ST_IDLE;
                end else if (wd_q == WD_LAST) begin
                    terr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            vert_q  <= '0;
            fill_q  <= 1'b0;
            color_q <= '0;
            pix_q   <= '0;
            tcnt_q  <= '0;
            terr_q  <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            vert_q  <= vert_d;
            fill_q  <= fill_d;
            color_q <= color_d;
            pix_q   <= pix_d;
            tcnt_q  <= tcnt_d;
            terr_q  <= terr_d;
            wd_q    <= wd_d;
        end
    end

    assign cmd_ready   = !fifo_full;
    assign tri_start   = (state_q == ST_START);
    assign tri_vert    = vert_q;
    assign tri_fill    = fill_q;
    assign tri_color   = color_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign pix_count   = pix_q;
    assign tri_count   = tcnt_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_triangle_cmd_sequencer.sv
// Directed bench for triangle_cmd_sequencer. u_dut (TIMEOUT_CYC=20) covers
// ordering, latency, stale-done, watchdog and reset; u_sat (TIMEOUT_CYC=100000)
// covers pixel-count saturation. Inputs change 1 time unit after posedge.
module tb_triangle_cmd_sequencer;
    import triangle_cmd_sequencer_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;

    logic        cmd_valid, cmd_ready, cmd_fill, tri_start, tri_fill;
    logic [47:0] cmd_vert, tri_vert;
    logic [23:0] cmd_color, tri_color;
    logic        tri_valid, tri_done, busy, timeout_err;
    logic [15:0] pix_count, tri_count;

    logic        s_cmd_valid, s_cmd_ready, s_cmd_fill, s_tri_start, s_tri_fill;
    logic [47:0] s_cmd_vert, s_tri_vert;
    logic [23:0] s_cmd_color, s_tri_color;
    logic        s_tri_valid, s_tri_done, s_busy, s_timeout_err;
    logic [15:0] s_pix_count, s_tri_count;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_start = -1;
    int          exp_tcnt = 0;
    bit          mon_en = 1'b0;
    logic [72:0] exp_q[$];
    logic [72:0] mon_exp;
    logic [72:0] cmds [5];

    triangle_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYC(20)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_vert(cmd_vert),
        .cmd_fill(cmd_fill), .cmd_color(cmd_color),
        .tri_start(tri_start), .tri_vert(tri_vert), .tri_fill(tri_fill),
        .tri_color(tri_color), .tri_valid(tri_valid), .tri_done(tri_done),
        .busy(busy), .pix_count(pix_count), .tri_count(tri_count),
        .timeout_err(timeout_err)
    );

    triangle_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYC(100000)) u_sat (
        .clk(clk), .rst(rst),
        .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_vert(s_cmd_vert),
        .cmd_fill(s_cmd_fill), .cmd_color(s_cmd_color),
        .tri_start(s_tri_start), .tri_vert(s_tri_vert), .tri_fill(s_tri_fill),
        .tri_color(s_tri_color), .tri_valid(s_tri_valid), .tri_done(s_tri_done),
        .busy(s_busy), .pix_count(s_pix_count), .tri_count(s_tri_count),
        .timeout_err(s_timeout_err)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL sim_time_limit observed=%0d cycles required=finish", cyc);
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [72:0] c);
        int n;
        n = 0;
        {cmd_vert, cmd_fill, cmd_color} = c;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            step();
            n++;
        end
        check("push_ready", 73'(cmd_ready), 73'd1);
        step();
        cmd_valid = 1'b0;
        exp_q.push_back(c);
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!tri_start && n < 100) begin
            step();
            n++;
        end
        check("start_seen", 73'(tri_start), 73'd1);
    endtask

    function automatic logic [72:0] rand_cmd();
        logic [47:0] v;
        v = pack_vert(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        return {v, 1'($urandom_range(0, 1)), 24'($urandom_range(0, 24'hFFFFFF))};
    endfunction

    task automatic check_reset_values();
        check("rst_tri_start", 73'(tri_start), 73'd0);
        check("rst_tri_vert", 73'(tri_vert), 73'd0);
        check("rst_tri_fill", 73'(tri_fill), 73'd0);
        check("rst_tri_color", 73'(tri_color), 73'd0);
        check("rst_pix_count", 73'(pix_count), 73'd0);
        check("rst_tri_count", 73'(tri_count), 73'd0);
        check("rst_timeout_err", 73'(timeout_err), 73'd0);
        check("rst_busy", 73'(busy), 73'd0);
        check("rst_cmd_ready", 73'(cmd_ready), 73'd1);
    endtask

    // Scoreboard: each start must carry the oldest outstanding command, starts
    // must be at least 4 cycles apart, and cmd_ready must track the occupancy
    // implied by the commands still waiting.
    always @(negedge clk) begin
        if (mon_en) begin
            if (tri_start) begin
                if (exp_q.size() == 0) begin
                    check("start_unexpected", 73'(tri_start), 73'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("start_cmd", {tri_vert, tri_fill, tri_color}, mon_exp);
                end
                if (last_start >= 0) check("start_gap", 73'(cyc - last_start >= 4), 73'd1);
                last_start = cyc;
            end
            check("ready_vs_occupancy", 73'(cmd_ready), 73'(exp_q.size() < DEPTH));
        end
    end

    initial begin
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_vert = '0; cmd_fill = 1'b0; cmd_color = '0;
        tri_valid = 1'b0; tri_done = 1'b0;
        s_cmd_valid = 1'b0; s_cmd_vert = '0; s_cmd_fill = 1'b0; s_cmd_color = '0;
        s_tri_valid = 1'b0; s_tri_done = 1'b0;
        repeat (3) step();
        check_reset_values();
        check("rst_sat_pix", 73'(s_pix_count), 73'd0);
        rst = 1'b1;
        step();
        mon_en = 1'b1;

        // Single command: latency, registered fields, pixel and triangle count.
        push_cmd({pack_vert(8'd128, 8'd10, 8'd20, 8'd230, 8'd236, 8'd230), 1'b1, 24'h87CEEB});
        check("lat_push_cycle", 73'(tri_start), 73'd0);
        step();
        check("lat_start_cycle", 73'(tri_start), 73'd1);
        check("single_vert", 73'(tri_vert), 73'h800A14E6ECE6);
        check("single_fill", 73'(tri_fill), 73'd1);
        check("single_color", 73'(tri_color), 73'h87CEEB);
        step();
        check("start_one_cycle", 73'(tri_start), 73'd0);
        tri_valid = 1'b1;
        repeat (5) step();
        tri_valid = 1'b0;
        tri_done = 1'b1;
        step();
        tri_done = 1'b0;
        exp_tcnt++;
        check("single_pix", 73'(pix_count), 73'd5);
        check("single_tcnt", 73'(tri_count), 73'(exp_tcnt));
        check("single_busy", 73'(busy), 73'd0);
        check("single_vert_hold", 73'(tri_vert), 73'h800A14E6ECE6);

        // Stale done held from the previous triangle through IDLE/START/ARM.
        push_cmd(rand_cmd());
        wait_start();
        repeat (2) step();
        tri_done = 1'b1;
        step();
        exp_tcnt++;
        check("stale_prev_tcnt", 73'(tri_count), 73'(exp_tcnt));
        push_cmd(rand_cmd());
        tri_valid = 1'b1;
        check("stale_idle_tcnt", 73'(tri_count), 73'(exp_tcnt));
        step();
        check("stale_start", 73'(tri_start), 73'd1);
        check("idle_valid_ignored", 73'(pix_count), 73'd0);
        step();
        check("start_valid_ignored", 73'(pix_count), 73'd0);
        step();
        check("arm_valid_counted", 73'(pix_count), 73'd1);
        check("arm_done_ignored", 73'(tri_count), 73'(exp_tcnt));
        check("arm_done_busy", 73'(busy), 73'd1);
        tri_done = 1'b0;
        tri_valid = 1'b0;
        repeat (3) step();
        check("wait_no_done_tcnt", 73'(tri_count), 73'(exp_tcnt));
        check("wait_no_done_busy", 73'(busy), 73'd1);
        tri_valid = 1'b1;
        tri_done = 1'b1;
        step();
        tri_valid = 1'b0;
        tri_done = 1'b0;
        exp_tcnt++;
        check("done_valid_same_pix", 73'(pix_count), 73'd2);
        check("done_valid_same_tcnt", 73'(tri_count), 73'(exp_tcnt));
        check("done_valid_same_busy", 73'(busy), 73'd0);

        // Five back-to-back commands with a 10-cycle rasterizer.
        for (int i = 0; i < 5; i++) cmds[i] = rand_cmd();
        fork
            begin
                for (int i = 0; i < 5; i++) push_cmd(cmds[i]);
                check("five_full_ready", 73'(cmd_ready), 73'd0);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    wait_start();
                    repeat (9) step();
                    check("five_fields_stable", {tri_vert, tri_fill, tri_color}, cmds[i]);
                    tri_done = 1'b1;
                    step();
                    tri_done = 1'b0;
                end
            end
        join
        exp_tcnt += 5;
        check("five_tcnt", 73'(tri_count), 73'(exp_tcnt));
        check("five_busy", 73'(busy), 73'd0);
        check("five_drained", 73'(exp_q.size()), 73'd0);

        // Watchdog: first command never completes, second must still run.
        push_cmd(rand_cmd());
        push_cmd(rand_cmd());
        wait_start();
        repeat (21) step();
        check("wd_before_limit", 73'(timeout_err), 73'd0);
        check("wd_before_busy", 73'(busy), 73'd1);
        step();
        check("wd_fired", 73'(timeout_err), 73'd1);
        check("wd_tcnt", 73'(tri_count), 73'(exp_tcnt));
        wait_start();
        repeat (2) step();
        tri_done = 1'b1;
        step();
        tri_done = 1'b0;
        exp_tcnt++;
        check("wd_next_tcnt", 73'(tri_count), 73'(exp_tcnt));
        check("wd_sticky", 73'(timeout_err), 73'd1);

        // Reset while in WAIT with two commands queued.
        push_cmd(rand_cmd());
        push_cmd(rand_cmd());
        push_cmd(rand_cmd());
        step();
        check("pre_reset_busy", 73'(busy), 73'd1);
        rst = 1'b0;
        step();
        exp_q.delete();
        exp_tcnt = 0;
        check_reset_values();
        rst = 1'b1;
        tri_done = 1'b1;
        step();
        tri_done = 1'b0;
        repeat (10) step();
        check("post_reset_tcnt", 73'(tri_count), 73'd0);
        check("post_reset_busy", 73'(busy), 73'd0);

        // Pixel counter saturation on the long-watchdog instance.
        s_cmd_vert = pack_vert(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6);
        s_cmd_fill = 1'b0;
        s_cmd_color = 24'h123456;
        check("sat_ready", 73'(s_cmd_ready), 73'd1);
        s_cmd_valid = 1'b1;
        step();
        s_cmd_valid = 1'b0;
        for (int n = 0; n < 100 && !s_tri_start; n++) step();
        check("sat_start", 73'(s_tri_start), 73'd1);
        s_tri_valid = 1'b1;
        repeat (65535) step();
        check("sat_below", 73'(s_pix_count), 73'hFFFE);
        step();
        check("sat_reached", 73'(s_pix_count), 73'hFFFF);
        repeat (70000 - 65536) step();
        check("sat_held", 73'(s_pix_count), 73'hFFFF);
        s_tri_valid = 1'b0;
        s_tri_done = 1'b1;
        step();
        s_tri_done = 1'b0;
        check("sat_tcnt", 73'(s_tri_count), 73'd1);
        check("sat_busy", 73'(s_busy), 73'd0);
        check("sat_no_timeout", 73'(s_timeout_err), 73'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/triangle_cmd_sequencer.md
TRIANGLE_CMD_SEQUENCER -- requirements
Module: triangle_cmd_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
- DEPTH, 4, command FIFO entries (power of two, >=2)
- TIMEOUT_CYC, 65535, WAIT-state watchdog limit in cycles
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset (rst=0 resets at the clk edge)
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept
- cmd_vert  in  48  {x0,y0,x1,y1,x2,y2}, 8b each, x0 in [47:40]
- cmd_fill  in  1  1=filled, 0=outline
- cmd_color  in  24  RGB888
- tri_start  out  1  one-cycle start pulse to rasterizer
- tri_vert  out  48  registered vertices to rasterizer, same packing
- tri_fill  out  1  registered fill_enable
- tri_color  out  24  registered colour
- tri_valid  in  1  rasterizer pixel strobe
- tri_done  in  1  rasterizer completion
- busy  out  1  state!=IDLE or FIFO non-empty
- pix_count  out  16  pixels of current/last triangle
- tri_count  out  16  triangles completed
- timeout_err  out  1  sticky watchdog flag

Function
REQ-003 FIFO SHALL store {vert,fill,color} (73b); push when cmd_valid&&cmd_ready; cmd_ready = !full.
REQ-004 Full FIFO SHALL hold cmd_ready=0 even in a pop cycle; no push/pop bypass.
REQ-005 FSM states SHALL be IDLE, START, ARM, WAIT.
REQ-006 IDLE with FIFO non-empty SHALL pop head into tri_vert/tri_fill/tri_color and go to START; empty FIFO SHALL stay in IDLE.
REQ-007 START SHALL drive tri_start=1 for exactly one cycle, clear pix_count, clear watchdog, go to ARM.
REQ-008 ARM SHALL last one cycle and ignore tri_done (stale level from previous triangle); go to WAIT.
REQ-009 WAIT SHALL return to IDLE on tri_done=1 and increment tri_count (mod 2^16).
REQ-010 tri_valid SHALL increment pix_count in ARM and WAIT only, saturating at 16'hFFFF; tri_valid and tri_done in the same cycle SHALL count the pixel.
REQ-011 Watchdog SHALL count WAIT cycles; on reaching TIMEOUT_CYC without tri_done, set timeout_err, leave tri_count unchanged, return to IDLE.
REQ-012 tri_done outside WAIT and tri_valid outside ARM/WAIT SHALL be ignored.
REQ-013 Latency: push into empty FIFO at edge T -> tri_start high during cycle T+1..T+2 (the cycle after IDLE pops); back-to-back commands SHALL give starts no closer than 4 cycles apart.
REQ-014 tri_vert/fill/color SHALL stay stable from START until the next pop.

Reset
REQ-015 rst=0 SHALL, at the clock edge, empty the FIFO, force IDLE, and set tri_start=0, tri_vert=0, tri_fill=0, tri_color=0, pix_count=0, tri_count=0, timeout_err=0, busy=0, cmd_ready=1.
REQ-016 Reset mid-WAIT SHALL abandon the triangle with no tri_count update; a later stale tri_done SHALL be ignored.
REQ-017 timeout_err SHALL clear only by reset.

Structure
REQ-018 Shared package SHALL hold: FSM state enum, command record type (73b), vertex-packing bit offsets.
REQ-019 FIFO SHALL be one sub-module, tri_cmd_fifo (DEPTH, WIDTH=73); the FSM/counters stay in the top.

Verification
REQ-020 Single cmd (128,10)/(20,230)/(236,230), fill=1, color 87CEEB; model 5 tri_valid then tri_done -> one tri_start, tri_vert=0x800A14E6ECE6, pix_count=5, tri_count=1, busy=0.
REQ-021 Push 5 cmds back-to-back, rasterizer done 10 cycles after each start -> cmd_ready=0 once 4 entries are queued (5th held until a pop), 5 starts in push order, tri_count=5.
REQ-022 tri_done held high from the previous triangle through START/ARM -> not taken as done; only done sampled in WAIT ends the triangle.
REQ-023 TIMEOUT_CYC=20, never assert tri_done -> timeout_err=1 after 20 WAIT cycles, tri_count=0, next queued cmd starts.
REQ-024 rst=0 in WAIT with 2 queued cmds -> all outputs at reset values next cycle, FIFO empty, no further tri_start.
REQ-025 tri_valid held for 70000 cycles with TIMEOUT_CYC=100000 -> pix_count saturates at FFFF.
